// File: rtl/qspim_rx.sv
// SPI master receive path: shifts sampled beats into 32-bit words and hands them to the rx FIFO.
// Define QSPIM_RX_QDDR_EN to make mode 11 sample a quad beat on every clk; otherwise mode 11 behaves as quad.
module qspim_rx (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        en,
    input  logic        rx_edge,
    input  logic        sdi0,
    input  logic        sdi1,
    input  logic        sdi2,
    input  logic        sdi3,
    input  logic [1:0]  s_spi_mode,
    input  logic [15:0] counter_in,
    input  logic        counter_in_upd,
    output logic [31:0] data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        rx_done,
    output logic        clk_en_o
);

    // state           | meaning
    // IDLE            | no transfer, SPI clock gated
    // RECEIVE         | sampling beats into the word register
    // WAIT_FIFO_SPACE | completed word held, SPI clock gated until data_ready
    localparam logic [1:0] IDLE            = 2'd0;
    localparam logic [1:0] RECEIVE         = 2'd1;
    localparam logic [1:0] WAIT_FIFO_SPACE = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [15:0] target_q, target_d;
    logic [1:0]  mode_q,   mode_d;
    logic [31:0] shift_q,  shift_d;
    logic [31:0] data_q,   data_d;
    logic        valid_q,  valid_d;
    logic        done_q,   done_d;

    logic        qddr_mode;
    logic        sample;
    logic        word_full;
    logic        last_beat;
    logic        fifo_free;
    logic [15:0] cnt_inc;
    logic [31:0] shift_nxt;

`ifdef QSPIM_RX_QDDR_EN
    assign qddr_mode = (mode_q == 2'b11);
`else
    assign qddr_mode = 1'b0;
`endif

    assign sample    = (state_q == RECEIVE) && en && (rx_edge || qddr_mode);
    assign cnt_inc   = cnt_q + 16'd1;
    assign last_beat = (cnt_inc == target_q);
    assign fifo_free = !valid_q || data_ready;

    // Words always start on a beat count that is a multiple of the word length,
    // so the low counter bits tell when the current word fills up.
    always_comb begin
        shift_nxt = shift_q;
        word_full = 1'b0;
        case (mode_q)
            2'b00: begin
                shift_nxt = {shift_q[30:0], sdi1};
                word_full = (cnt_q[4:0] == 5'd31);
            end
            2'b01: begin
                shift_nxt = {shift_q[29:0], sdi1, sdi0};
                word_full = (cnt_q[3:0] == 4'hF);
            end
            default: begin
                shift_nxt = {shift_q[27:0], sdi3, sdi2, sdi1, sdi0};
                word_full = (cnt_q[2:0] == 3'd7);
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        mode_d   = mode_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q && !data_ready;
        done_d   = 1'b0;

        if (counter_in_upd) begin
            mode_d = s_spi_mode;
            case (s_spi_mode)
                2'b00:   target_d = counter_in;
                2'b01:   target_d = {1'b0, counter_in[15:1]};
                default: target_d = {2'b00, counter_in[15:2]};
            endcase
        end

        case (state_q)
            IDLE: begin
                if (en && (target_q != 16'd0)) begin
                    state_d = RECEIVE;
                    cnt_d   = 16'd0;
                    shift_d = 32'd0;
                end
            end
            RECEIVE: begin
                if (!en) begin
                    state_d = IDLE;
                    shift_d = 32'd0;
                end else if (sample) begin
                    cnt_d  = cnt_inc;
                    done_d = last_beat;
                    if (word_full || last_beat) begin
                        if (fifo_free) begin
                            data_d  = shift_nxt;
                            valid_d = 1'b1;
                            shift_d = 32'd0;
                            if (last_beat) state_d = IDLE;
                        end else begin
                            shift_d = shift_nxt;
                            state_d = WAIT_FIFO_SPACE;
                        end
                    end else begin
                        shift_d = shift_nxt;
                    end
                end
            end
            WAIT_FIFO_SPACE: begin
                if (!en) begin
                    state_d = IDLE;
                    shift_d = 32'd0;
                end else if (data_ready) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    shift_d = 32'd0;
                    state_d = (cnt_q == target_q) ? IDLE : RECEIVE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            cnt_d    = 16'd0;
            shift_d  = 32'd0;
            valid_d  = 1'b0;
            target_d = 16'd0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            target_q <= 16'd0;
            mode_q   <= 2'b00;
            shift_q  <= 32'd0;
            data_q   <= 32'd0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            mode_q   <= mode_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign rx_done    = done_q;
    assign clk_en_o   = (state_d == RECEIVE);

endmodule

// File: tb/tb_qspim_rx.sv
// Scoreboard bench for qspim_rx: expected words are queued by the stimulus and popped on each FIFO handshake.
module tb_qspim_rx;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        en = 1'b0;
    logic        rx_edge = 1'b0;
    logic        sdi0 = 1'b0, sdi1 = 1'b0, sdi2 = 1'b0, sdi3 = 1'b0;
    logic [1:0]  s_spi_mode = 2'b00;
    logic [15:0] counter_in = 16'd0;
    logic        counter_in_upd = 1'b0;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready = 1'b1;
    logic        rx_done;
    logic        clk_en_o;

    int          n_tests = 0;
    int          n_fail = 0;
    int          done_seen = 0;
    int          done_exp = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    qspim_rx dut (
        .clk(clk), .rstn(rstn), .flush(flush), .en(en), .rx_edge(rx_edge),
        .sdi0(sdi0), .sdi1(sdi1), .sdi2(sdi2), .sdi3(sdi3),
        .s_spi_mode(s_spi_mode), .counter_in(counter_in), .counter_in_upd(counter_in_upd),
        .data(data), .data_valid(data_valid), .data_ready(data_ready),
        .rx_done(rx_done), .clk_en_o(clk_en_o)
    );

    always #5 clk = ~clk;

    // Monitor: a word is consumed on every clk where data_valid and data_ready are both high.
    always @(negedge clk) begin
        #2;
        if (rstn && data_valid && data_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got word %h, required no word", data);
            end else begin
                exp_w = exp_q.pop_front();
                if (data !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_word: got %h, required %h", data, exp_w);
                end
            end
        end
        if (rx_done === 1'b1) done_seen++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic beat(input logic [3:0] nib);
        @(negedge clk);
        {sdi3, sdi2, sdi1, sdi0} = nib;
        rx_edge = 1'b1;
        @(negedge clk);
        rx_edge = 1'b0;
    endtask

    task automatic start(input logic [1:0] mode, input logic [15:0] len);
        @(negedge clk);
        s_spi_mode = mode;
        counter_in = len;
        counter_in_upd = 1'b1;
        @(negedge clk);
        counter_in_upd = 1'b0;
        en = 1'b1;
    endtask

    task automatic finish_xfer(input string name);
        repeat (4) @(negedge clk);
        #2;
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_done"}, done_seen, done_exp);
    endtask

    initial begin
        logic [31:0] w;

        repeat (3) @(negedge clk);
        #2;
        check("rst_data", data, 32'h0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_done", rx_done, 1'b0);
        check("rst_clk_en", clk_en_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Single mode, 32 bits MSB first on sdi1
        w = 32'hA5A5_1234;
        exp_q.push_back(w);
        done_exp++;
        start(2'b00, 16'd32);
        for (int i = 31; i >= 0; i--) beat({2'b00, w[i], 1'b0});
        en = 1'b0;
        finish_xfer("single");

        // Quad mode, two words
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h9ABC_DEF0);
        done_exp++;
        start(2'b10, 16'd64);
        for (int i = 1; i <= 16; i++) beat(4'(i));
        en = 1'b0;
        finish_xfer("quad");

        // Backpressure: second word completes while first is unread
        data_ready = 1'b0;
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h9ABC_DEF0);
        exp_q.push_back(32'h1234_5678);
        done_exp++;
        start(2'b10, 16'd96);
        for (int i = 1; i <= 16; i++) beat(4'(i));
        #2;
        check("bp_clk_en", clk_en_o, 1'b0);
        check("bp_valid", data_valid, 1'b1);
        check("bp_hold", data, 32'h1234_5678);
        for (int i = 0; i < 3; i++) beat(4'h5);
        #2;
        check("bp_clk_en_hold", clk_en_o, 1'b0);
        @(negedge clk);
        data_ready = 1'b1;
        #2;
        check("bp_resume_clk_en", clk_en_o, 1'b1);
        @(negedge clk);
        for (int i = 1; i <= 8; i++) beat(4'(i));
        en = 1'b0;
        finish_xfer("bp");

        // Double mode partial word left pending with data_ready low
        data_ready = 1'b0;
        done_exp++;
        start(2'b01, 16'd8);
        beat(4'b0011);
        beat(4'b0001);
        beat(4'b0000);
        beat(4'b0010);
        en = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("dbl_data", data, 32'h0000_00D2);
        check("dbl_valid_held", data_valid, 1'b1);
        check("dbl_done", done_seen, done_exp);

        // Flush at beat 5 of a single 32-bit transfer
        start(2'b00, 16'd32);
        for (int i = 0; i < 5; i++) beat(4'b0010);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #2;
        check("flush_clk_en", clk_en_o, 1'b0);
        check("flush_valid", data_valid, 1'b0);
        for (int i = 0; i < 3; i++) beat(4'b0010);
        #2;
        check("flush_idle", clk_en_o, 1'b0);
        en = 1'b0;
        data_ready = 1'b1;
        finish_xfer("flush");

        // Mode 11: every clk with the QDDR build, rx_edge-driven otherwise
        exp_q.push_back(32'h1234_5678);
        done_exp++;
        start(2'b11, 16'd32);
`ifdef QSPIM_RX_QDDR_EN
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            {sdi3, sdi2, sdi1, sdi0} = 4'(i);
        end
        @(negedge clk);
`else
        for (int i = 1; i <= 8; i++) beat(4'(i));
`endif
        en = 1'b0;
        finish_xfer("qddr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/qspim_rx.md
QSPIM_RX -- requirements
Module: qspim_rx

Interface
REQ-001 SHALL have port: clk  input  1  SPI core clock (all logic on rising edge).
REQ-002 SHALL have port: rstn  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: flush  input  1  synchronous abort; returns block to IDLE.
REQ-004 SHALL have port: en  input  1  receive enable.
REQ-005 SHALL have port: rx_edge  input  1  sampling-edge strobe, one clk wide.
REQ-006 SHALL have ports: sdi0, sdi1, sdi2, sdi3  input  1 each  SPI data-in lines.
REQ-007 SHALL have port: s_spi_mode  input  2  00 single, 01 double, 10 quad, 11 QDDR.
REQ-008 SHALL have port: counter_in  input  16  total receive length in bits.
REQ-009 SHALL have port: counter_in_upd  input  1  loads counter_in as the new target.
REQ-010 SHALL have port: data  output  32  received word to rxfifo.
REQ-011 SHALL have port: data_valid  output  1  data holds an unread word.
REQ-012 SHALL have port: data_ready  input  1  rxfifo accepts data this cycle.
REQ-013 SHALL have port: rx_done  output  1  one-clk pulse on the final sampled beat.
REQ-014 SHALL have port: clk_en_o  output  1  SPI clock enable; 1 only while next state is RECEIVE.

Function
REQ-015 SHALL use states IDLE, RECEIVE and WAIT_FIFO_SPACE.
REQ-016 SHALL load target on counter_in_upd=1:
- single = counter_in
- double = counter_in>>1
- quad/QDDR = counter_in>>2
- mode is latched at the same time.
REQ-017 SHALL move IDLE->RECEIVE when en=1 and target!=0; beat counter is cleared.
REQ-018 SHALL sample one beat per rx_edge in RECEIVE and left-shift it into the word register:
- single: sdi1
- double: {sdi1,sdi0}
- quad: {sdi3,sdi2,sdi1,sdi0}
REQ-019 SHALL mark the word complete at 32, 16 or 8 beats (single/double/quad), or on the final beat.
REQ-020 SHALL right-align a partial final word, with unfilled upper bits 0.
REQ-021 SHALL, on word complete with data_valid=0 (or data_ready=1 in the same cycle):
- copy the word to data
- assert data_valid on the next clk.
REQ-022 SHALL, on word complete with data_valid=1 and data_ready=0:
- move to WAIT_FIFO_SPACE
- deassert clk_en_o
- hold the word
- leave WAIT_FIFO_SPACE on data_ready=1 by transferring the word and resuming RECEIVE, or IDLE if it was the final beat.
REQ-023 SHALL hold data_valid until the clk on which data_ready=1; data SHALL stay stable while data_valid=1.
REQ-024 SHALL pulse rx_done for exactly one clk when beat count+1 equals target in RECEIVE, then go to IDLE.
REQ-025 SHALL abort the transfer when en drops mid-transfer: go to IDLE, keep the pending data_valid word, discard the partial word.
REQ-026 SHALL, on flush=1, clear in the same clk: state, counter, shift register, data_valid and target; flush overrides all other events.
REQ-027 SHALL never sample while clk_en_o=0.

Reset
REQ-028 SHALL, while rstn=0, force:
- state=IDLE
- data=0, data_valid=0
- rx_done=0, clk_en_o=0
- counter=0, target=0
- mode=single

Configuration
REQ-029 SHALL support QDDR sampling only when macro QSPIM_RX_QDDR_EN is defined: mode 11 samples a quad beat on every clk in RECEIVE, ignoring rx_edge.
REQ-030 SHALL, without QSPIM_RX_QDDR_EN, treat mode 11 exactly as quad (10).

Verification
REQ-031 SHALL cover single mode: counter_in=32, sdi1 serial 0xA5A5_1234 MSB first -> data=0xA5A51234, data_valid=1, rx_done after beat 32.
REQ-032 SHALL cover quad mode: counter_in=64, nibbles 0x1,0x2,...,0xF,0x0 -> two words 0x12345678 then 0x9ABCDEF0, 16 rx_edges.
REQ-033 SHALL cover backpressure: data_ready=0 while 2nd word completes -> WAIT_FIFO_SPACE, clk_en_o=0, no sampling; data_ready=1 -> 1st word consumed, 2nd word presented.
REQ-034 SHALL cover double mode partial word: counter_in=8, beats 11,01,00,10 -> data=0x000000D2.
REQ-035 SHALL cover flush at beat 5 of single 32-bit transfer -> IDLE next clk, data_valid=0, no rx_done.
REQ-036 SHALL cover QDDR with QSPIM_RX_QDDR_EN: mode 11, counter_in=32, rx_edge=0 -> word captured in 8 consecutive clks; without the macro -> 8 rx_edges.
